// File: rtl/riscv_state_checker.sv
// End-of-program monitor: detects core halt or timeout, then scans the register file and the
// low data-memory bytes against a preloaded expected table and reports the first failure.
module riscv_state_checker #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned NREGS       = 32,
   parameter int unsigned MEM_BYTES   = 128,
   parameter int unsigned CHECK_BYTES = 32,
   parameter int unsigned TIMEOUT     = 1024,
   parameter int unsigned HALT_REPEAT = 2
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_start,
   input  logic [XLEN-1:0]              i_pc_in,
   output logic [$clog2(NREGS)-1:0]     o_reg_raddr,
   input  logic [XLEN-1:0]              i_reg_rdata,
   output logic [$clog2(MEM_BYTES)-1:0] o_mem_raddr,
   input  logic [7:0]                   i_mem_rdata,
   input  logic                         i_exp_we,
   input  logic                         i_exp_sel,
   input  logic [$clog2(MEM_BYTES)-1:0] i_exp_addr,
   input  logic [XLEN-1:0]              i_exp_data,
   input  logic                         i_exp_en,
   output logic                         o_busy,
   output logic                         o_done,
   output logic                         o_pass,
   output logic                         o_timed_out,
   output logic [15:0]                  o_mismatch_count,
   output logic                         o_fail_valid,
   output logic                         o_fail_is_mem,
   output logic [7:0]                   o_fail_index,
   output logic [XLEN-1:0]              o_fail_actual,
   output logic [XLEN-1:0]              o_fail_expected,
   output logic [31:0]                  o_cycle_count
);

   localparam int unsigned RA_W  = $clog2(NREGS);
   localparam int unsigned MA_W  = $clog2(MEM_BYTES);
   localparam int unsigned IW    = (RA_W > MA_W) ? RA_W : MA_W;
   localparam int unsigned FI_W  = (IW < 8) ? IW : 8;

   typedef enum logic [2:0] {
      StIdle,
      StRun,
      StScanReg,
      StScanMem,
      StDrain,
      StDone
   } state_e;

   state_e             r_state;
   state_e             w_state_nxt;

   logic [XLEN-1:0]    r_exp_reg [NREGS];
   logic [7:0]         r_exp_mem [MEM_BYTES];
   logic [NREGS-1:0]   r_en_reg;
   logic [MEM_BYTES-1:0] r_en_mem;

   logic [31:0]        r_cycle_count;
   logic [31:0]        r_stable;
   logic [XLEN-1:0]    r_pc_q;
   logic               r_pc_vld;
   logic               r_timed_out;
   logic [IW-1:0]      r_idx;

   logic               r_cmp_vld;
   logic               r_cmp_is_mem;
   logic [IW-1:0]      r_cmp_idx;

   logic [15:0]        r_mis_cnt;
   logic               r_fail_valid;
   logic               r_fail_is_mem;
   logic [7:0]         r_fail_index;
   logic [XLEN-1:0]    r_fail_actual;
   logic [XLEN-1:0]    r_fail_expected;

   logic               w_idle_or_done;
   logic               w_start_ok;
   logic               w_load_ok;
   logic [IW-1:0]      w_addr_ext;
   logic [RA_W-1:0]    w_load_ridx;
   logic               w_pc_same;
   logic [31:0]        w_stable_d;
   logic               w_halt;
   logic               w_timeout;
   logic               w_last_reg;
   logic               w_last_mem;
   logic [RA_W-1:0]    w_cmp_ridx;
   logic [MA_W-1:0]    w_cmp_midx;
   logic [XLEN-1:0]    w_actual;
   logic [XLEN-1:0]    w_expect;
   logic               w_cmp_en;
   logic               w_mis;
   logic [7:0]         w_fail_idx;

   assign w_idle_or_done = (r_state == StIdle) || (r_state == StDone);
   assign w_start_ok     = i_start && w_idle_or_done;
   assign w_load_ok      = i_exp_we && w_idle_or_done;
   assign w_addr_ext     = IW'(i_exp_addr);
   assign w_load_ridx    = w_addr_ext[RA_W-1:0];

   // The first sample after start has no predecessor, so it can never count as stable.
   assign w_pc_same  = r_pc_vld && (i_pc_in == r_pc_q);
   assign w_stable_d = w_pc_same ? (r_stable + 32'd1) : 32'd0;
   assign w_halt     = w_pc_same && (w_stable_d >= 32'(HALT_REPEAT - 1));
   assign w_timeout  = (r_cycle_count == 32'(TIMEOUT - 1));
   assign w_last_reg = (r_idx == IW'(NREGS - 1));
   assign w_last_mem = (r_idx == IW'(CHECK_BYTES - 1));

   // ---------------- FSM: state register ----------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         StIdle, StDone: if (i_start)                w_state_nxt = StRun;
         StRun:          if (w_halt || w_timeout)    w_state_nxt = StScanReg;
         StScanReg:      if (w_last_reg)             w_state_nxt = StScanMem;
         StScanMem:      if (w_last_mem)             w_state_nxt = StDrain;
         StDrain:                                    w_state_nxt = StDone;
         default:                                    w_state_nxt = StIdle;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      o_busy      = 1'b0;
      o_done      = 1'b0;
      o_pass      = 1'b0;
      o_reg_raddr = '0;
      o_mem_raddr = '0;
      case (r_state)
         StRun, StDrain: o_busy = 1'b1;
         StScanReg: begin
            o_busy      = 1'b1;
            o_reg_raddr = r_idx[RA_W-1:0];
         end
         StScanMem: begin
            o_busy      = 1'b1;
            o_mem_raddr = r_idx[MA_W-1:0];
         end
         StDone: begin
            o_done = 1'b1;
            o_pass = (r_mis_cnt == 16'd0) && !r_timed_out;
         end
         default: ;
      endcase
   end

   // Expected values are deliberately left unreset; only the enables are cleared.
   always_ff @(posedge i_clk) begin
      if (w_load_ok) begin
         if (i_exp_sel) r_exp_mem[i_exp_addr]  <= i_exp_data[7:0];
         else           r_exp_reg[w_load_ridx] <= i_exp_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_en_reg <= '0;
         r_en_mem <= '0;
      end else if (w_load_ok) begin
         if (i_exp_sel) r_en_mem[i_exp_addr]  <= i_exp_en;
         else           r_en_reg[w_load_ridx] <= i_exp_en;
      end
   end

   // Run tracking and scan index.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cycle_count <= '0;
         r_stable      <= '0;
         r_pc_q        <= '0;
         r_pc_vld      <= 1'b0;
         r_timed_out   <= 1'b0;
         r_idx         <= '0;
      end else if (w_start_ok) begin
         r_cycle_count <= '0;
         r_stable      <= '0;
         r_pc_vld      <= 1'b0;
         r_timed_out   <= 1'b0;
         r_idx         <= '0;
      end else begin
         if (r_state == StRun) begin
            r_cycle_count <= r_cycle_count + 32'd1;
            r_pc_q        <= i_pc_in;
            r_pc_vld      <= 1'b1;
            r_stable      <= w_stable_d;
            if (w_timeout && !w_halt) r_timed_out <= 1'b1;
         end
         if (r_state == StScanReg) r_idx <= w_last_reg ? '0 : r_idx + 1'b1;
         if (r_state == StScanMem) r_idx <= w_last_mem ? '0 : r_idx + 1'b1;
      end
   end

   // Compare stage: index issued in cycle t is checked in t+1 against returned data.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cmp_vld    <= 1'b0;
         r_cmp_is_mem <= 1'b0;
         r_cmp_idx    <= '0;
      end else begin
         r_cmp_vld    <= (r_state == StScanReg) || (r_state == StScanMem);
         r_cmp_is_mem <= (r_state == StScanMem);
         r_cmp_idx    <= r_idx;
      end
   end

   assign w_cmp_ridx = r_cmp_idx[RA_W-1:0];
   assign w_cmp_midx = r_cmp_idx[MA_W-1:0];

   always_comb begin
      w_fail_idx = '0;
      for (int b = 0; b < FI_W; b++) w_fail_idx[b] = r_cmp_idx[b];
   end

   always_comb begin
      if (r_cmp_is_mem) begin
         w_actual = {{(XLEN-8){1'b0}}, i_mem_rdata};
         w_expect = {{(XLEN-8){1'b0}}, r_exp_mem[w_cmp_midx]};
         w_cmp_en = r_en_mem[w_cmp_midx];
      end else begin
         w_actual = i_reg_rdata;
         w_expect = r_exp_reg[w_cmp_ridx];
         w_cmp_en = r_en_reg[w_cmp_ridx];
      end
   end

   assign w_mis = r_cmp_vld && w_cmp_en && (w_actual != w_expect);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_mis_cnt       <= '0;
         r_fail_valid    <= 1'b0;
         r_fail_is_mem   <= 1'b0;
         r_fail_index    <= '0;
         r_fail_actual   <= '0;
         r_fail_expected <= '0;
      end else if (w_start_ok) begin
         r_mis_cnt       <= '0;
         r_fail_valid    <= 1'b0;
         r_fail_is_mem   <= 1'b0;
         r_fail_index    <= '0;
         r_fail_actual   <= '0;
         r_fail_expected <= '0;
      end else if (w_mis) begin
         if (r_mis_cnt != 16'hFFFF) r_mis_cnt <= r_mis_cnt + 16'd1;
         if (!r_fail_valid) begin
            r_fail_valid    <= 1'b1;
            r_fail_is_mem   <= r_cmp_is_mem;
            r_fail_index    <= w_fail_idx;
            r_fail_actual   <= w_actual;
            r_fail_expected <= w_expect;
         end
      end
   end

   assign o_timed_out      = r_timed_out;
   assign o_mismatch_count = r_mis_cnt;
   assign o_fail_valid     = r_fail_valid;
   assign o_fail_is_mem    = r_fail_is_mem;
   assign o_fail_index     = r_fail_index;
   assign o_fail_actual    = r_fail_actual;
   assign o_fail_expected  = r_fail_expected;
   assign o_cycle_count    = r_cycle_count;

endmodule

// File: tb/tb_riscv_state_checker.sv
// Directed bench: dut_a uses default parameters; dut_b uses TIMEOUT=16 and a full 256-byte scan.
module tb_riscv_state_checker;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, start_a, start_b, we_a, we_b, exp_sel, exp_en;
   logic [7:0]  exp_addr;
   logic [31:0] exp_data, pc;

   logic [4:0]  reg_raddr_a, reg_raddr_b;
   logic [6:0]  mem_raddr_a;
   logic [7:0]  mem_raddr_b;
   logic [31:0] rd_a, rd_b;
   logic [7:0]  md_a, md_b;
   logic        busy_a, done_a, pass_a, to_a, fv_a, fm_a;
   logic        busy_b, done_b, pass_b, to_b, fv_b, fm_b;
   logic [15:0] mc_a, mc_b;
   logic [7:0]  fi_a, fi_b;
   logic [31:0] fa_a, fe_a, cc_a, fa_b, fe_b, cc_b;

   logic [31:0] stub_reg [32];
   logic [7:0]  stub_mem [256];

   int n_checks = 0;
   int n_errors = 0;

   riscv_state_checker dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a), .i_pc_in(pc),
      .o_reg_raddr(reg_raddr_a), .i_reg_rdata(rd_a), .o_mem_raddr(mem_raddr_a),
      .i_mem_rdata(md_a), .i_exp_we(we_a), .i_exp_sel(exp_sel), .i_exp_addr(exp_addr[6:0]),
      .i_exp_data(exp_data), .i_exp_en(exp_en), .o_busy(busy_a), .o_done(done_a),
      .o_pass(pass_a), .o_timed_out(to_a), .o_mismatch_count(mc_a), .o_fail_valid(fv_a),
      .o_fail_is_mem(fm_a), .o_fail_index(fi_a), .o_fail_actual(fa_a),
      .o_fail_expected(fe_a), .o_cycle_count(cc_a)
   );

   riscv_state_checker #(.MEM_BYTES(256), .CHECK_BYTES(256), .TIMEOUT(16)) dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .i_pc_in(pc),
      .o_reg_raddr(reg_raddr_b), .i_reg_rdata(rd_b), .o_mem_raddr(mem_raddr_b),
      .i_mem_rdata(md_b), .i_exp_we(we_b), .i_exp_sel(exp_sel), .i_exp_addr(exp_addr),
      .i_exp_data(exp_data), .i_exp_en(exp_en), .o_busy(busy_b), .o_done(done_b),
      .o_pass(pass_b), .o_timed_out(to_b), .o_mismatch_count(mc_b), .o_fail_valid(fv_b),
      .o_fail_is_mem(fm_b), .o_fail_index(fi_b), .o_fail_actual(fa_b),
      .o_fail_expected(fe_b), .o_cycle_count(cc_b)
   );

   // Stub core storage with one-cycle read latency.
   always_ff @(posedge clk) begin
      rd_a <= stub_reg[reg_raddr_a];
      md_a <= stub_mem[{1'b0, mem_raddr_a}];
      rd_b <= stub_reg[reg_raddr_b];
      md_b <= stub_mem[mem_raddr_b];
   end

   task automatic load(input bit to_b, input bit sel, input int addr, input logic [31:0] data,
                       input bit en);
      @(negedge clk);
      we_a = !to_b; we_b = to_b; exp_sel = sel; exp_addr = addr[7:0];
      exp_data = data; exp_en = en;
      @(negedge clk);
      we_a = 1'b0; we_b = 1'b0;
   endtask

   task automatic load_std(input bit to_b);
      load(to_b, 0, 5, 32'h7, 1);
      load(to_b, 0, 6, 32'h0, 1);
      load(to_b, 0, 7, 32'h0, 1);
      load(to_b, 0, 8, 32'h0000F0F0, 1);
      load(to_b, 0, 9, 32'h3, 1);
      load(to_b, 1, 4, 32'h0F, 1);
   endtask

   task automatic set_stubs();
      for (int i = 0; i < 32; i++) stub_reg[i] = 32'h0;
      for (int i = 0; i < 256; i++) stub_mem[i] = 8'h0;
      stub_reg[5] = 32'h7; stub_reg[8] = 32'h0000F0F0; stub_reg[9] = 32'h3;
      stub_mem[4] = 8'h0F;
   endtask

   // Starts a run; pc ramps by 4 per RUN cycle, then parks at 0x40 from RUN cycle 10 unless
   // ramp is set. lat counts clock edges from the start edge until done is seen.
   task automatic run(input bit on_b, input bit ramp, input bit poke, output int lat);
      @(negedge clk);
      if (on_b) start_b = 1'b1; else start_a = 1'b1;
      lat = 0;
      for (int c = 0; c < 1000; c++) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         start_a = 1'b0; start_b = 1'b0; we_a = 1'b0;
         pc = (ramp || lat < 11) ? 32'((lat - 1) * 4) : 32'h40;
         if (poke && lat == 4) begin
            start_a = 1'b1; we_a = 1'b1; exp_sel = 1'b0; exp_addr = 8'd5;
            exp_data = 32'h99; exp_en = 1'b1;
         end
         if ((on_b ? done_b : done_a) == 1'b1) break;
      end
   endtask

   task automatic test_reset();
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      n_checks++; if ({busy_a, done_a, pass_a, to_a, fv_a, fm_a} !== 6'b0) begin
         n_errors++; $display("FAIL reset_flags: got %b want 000000",
                              {busy_a, done_a, pass_a, to_a, fv_a, fm_a}); end
      n_checks++; if (mc_a !== 16'd0) begin
         n_errors++; $display("FAIL reset_mc: got %0d want 0", mc_a); end
      n_checks++; if (cc_a !== 32'd0) begin
         n_errors++; $display("FAIL reset_cc: got %0d want 0", cc_a); end
      n_checks++; if ({reg_raddr_a, mem_raddr_a} !== 12'd0) begin
         n_errors++; $display("FAIL reset_raddr: got %h/%h want 0", reg_raddr_a, mem_raddr_a); end
      n_checks++; if ({fi_a, fa_a, fe_a} !== 72'd0) begin
         n_errors++; $display("FAIL reset_fail: got %h %h %h want 0", fi_a, fa_a, fe_a); end
   endtask

   task automatic test_pass();
      int lat;
      load_std(0);
      run(0, 0, 0, lat);
      n_checks++; if (lat !== 78) begin
         n_errors++; $display("FAIL pass_latency: got %0d want 78", lat); end
      n_checks++; if (pass_a !== 1'b1) begin
         n_errors++; $display("FAIL pass_pass: got %b want 1", pass_a); end
      n_checks++; if (mc_a !== 16'd0) begin
         n_errors++; $display("FAIL pass_mc: got %0d want 0", mc_a); end
      n_checks++; if ({to_a, fv_a, busy_a} !== 3'b000) begin
         n_errors++; $display("FAIL pass_flags: got %b want 000", {to_a, fv_a, busy_a}); end
      n_checks++; if (cc_a !== 32'd12) begin
         n_errors++; $display("FAIL pass_cc: got %0d want 12", cc_a); end
   endtask

   task automatic test_mismatch();
      int lat;
      stub_reg[8] = 32'h0000F0F1; stub_mem[4] = 8'h0E;
      run(0, 0, 0, lat);
      n_checks++; if (mc_a !== 16'd2) begin
         n_errors++; $display("FAIL mis_mc: got %0d want 2", mc_a); end
      n_checks++; if ({done_a, fv_a, fm_a, pass_a} !== 4'b1100) begin
         n_errors++; $display("FAIL mis_flags: got %b want 1100", {done_a, fv_a, fm_a, pass_a}); end
      n_checks++; if (fi_a !== 8'd8) begin
         n_errors++; $display("FAIL mis_index: got %0d want 8", fi_a); end
      n_checks++; if (fa_a !== 32'h0000F0F1) begin
         n_errors++; $display("FAIL mis_actual: got %h want 0000f0f1", fa_a); end
      n_checks++; if (fe_a !== 32'h0000F0F0) begin
         n_errors++; $display("FAIL mis_expected: got %h want 0000f0f0", fe_a); end
   endtask

   task automatic test_back_to_back();
      int lat;
      set_stubs();
      stub_reg[10] = 32'h1234;
      load(0, 0, 10, 32'h55, 0);
      run(0, 0, 0, lat);
      n_checks++; if (lat !== 78) begin
         n_errors++; $display("FAIL b2b_latency: got %0d want 78", lat); end
      n_checks++; if (mc_a !== 16'd0) begin
         n_errors++; $display("FAIL b2b_mc: got %0d want 0", mc_a); end
      n_checks++; if ({fv_a, fi_a, fa_a, fe_a} !== 73'd0) begin
         n_errors++; $display("FAIL b2b_fail_clear: got %b %h %h %h want 0", fv_a, fi_a, fa_a, fe_a); end
      n_checks++; if (pass_a !== 1'b1) begin
         n_errors++; $display("FAIL b2b_dont_care_pass: got %b want 1", pass_a); end
   endtask

   task automatic test_ignore_in_run();
      int lat;
      run(0, 0, 1, lat);
      n_checks++; if (cc_a !== 32'd12) begin
         n_errors++; $display("FAIL ignore_cc: got %0d want 12", cc_a); end
      n_checks++; if (lat !== 78) begin
         n_errors++; $display("FAIL ignore_latency: got %0d want 78", lat); end
      n_checks++; if (pass_a !== 1'b1) begin
         n_errors++; $display("FAIL ignore_table: got pass %b want 1", pass_a); end
   endtask

   task automatic test_abort();
      bit found = 1'b0;
      int lat;
      @(negedge clk); start_a = 1'b1;
      for (int c = 0; c < 200; c++) begin
         @(posedge clk);
         @(negedge clk);
         start_a = 1'b0;
         pc = (c < 10) ? 32'(c * 4) : 32'h40;
         if (reg_raddr_a == 5'd5) begin found = 1'b1; break; end
      end
      n_checks++; if ({found, busy_a} !== 2'b11) begin
         n_errors++; $display("FAIL abort_reach_scan: got %b want 11", {found, busy_a}); end
      rst_n = 1'b0;
      #1;
      n_checks++; if ({busy_a, done_a, pass_a, reg_raddr_a} !== 8'd0) begin
         n_errors++; $display("FAIL abort_outputs: got %b want 0",
                              {busy_a, done_a, pass_a, reg_raddr_a}); end
      n_checks++; if ({cc_a, mc_a} !== 48'd0) begin
         n_errors++; $display("FAIL abort_counts: got %0d %0d want 0 0", cc_a, mc_a); end
      @(negedge clk); rst_n = 1'b1;
      // Enables were cleared by reset, so a bad x8 must not be reported.
      stub_reg[8] = 32'h0000F0F1;
      run(0, 0, 0, lat);
      n_checks++; if ({pass_a, mc_a} !== {1'b1, 16'd0}) begin
         n_errors++; $display("FAIL abort_en_cleared: got pass %b mc %0d want 1 0", pass_a, mc_a); end
      stub_reg[8] = 32'h0000F0F0;
   endtask

   task automatic test_timeout();
      int lat;
      load_std(1);
      run(1, 1, 0, lat);
      n_checks++; if (to_b !== 1'b1) begin
         n_errors++; $display("FAIL to_flag: got %b want 1", to_b); end
      n_checks++; if (cc_b !== 32'd16) begin
         n_errors++; $display("FAIL to_cc: got %0d want 16", cc_b); end
      n_checks++; if ({pass_b, mc_b} !== 17'd0) begin
         n_errors++; $display("FAIL to_pass: got %b mc %0d want 0 0", pass_b, mc_b); end
      n_checks++; if (lat !== 306) begin
         n_errors++; $display("FAIL to_latency: got %0d want 306", lat); end
   endtask

   task automatic test_last_byte();
      int lat;
      stub_mem[255] = 8'hAB;
      load(1, 1, 255, 32'hAA, 1);
      run(1, 0, 0, lat);
      n_checks++; if (lat !== 302) begin
         n_errors++; $display("FAIL last_latency: got %0d want 302", lat); end
      n_checks++; if ({to_b, fv_b, fm_b, pass_b} !== 4'b0110) begin
         n_errors++; $display("FAIL last_flags: got %b want 0110", {to_b, fv_b, fm_b, pass_b}); end
      n_checks++; if (mc_b !== 16'd1) begin
         n_errors++; $display("FAIL last_mc: got %0d want 1", mc_b); end
      n_checks++; if (fi_b !== 8'd255) begin
         n_errors++; $display("FAIL last_index: got %0d want 255", fi_b); end
      n_checks++; if ({fa_b, fe_b} !== {32'hAB, 32'hAA}) begin
         n_errors++; $display("FAIL last_values: got %h/%h want ab/aa", fa_b, fe_b); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
      exp_sel = 1'b0; exp_en = 1'b0; exp_addr = 8'd0; exp_data = 32'd0; pc = 32'd0;
      set_stubs();
      repeat (3) @(negedge clk);
      test_reset();
      test_pass();
      test_mismatch();
      test_back_to_back();
      test_ignore_in_run();
      test_abort();
      test_timeout();
      test_last_byte();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/riscv_state_checker.md
Name: riscv_state_checker

Overview:
- Self-checking end-of-program monitor for the single-cycle riscv core.
- Replaces fixed-delay, display-only result dumps with hardware halt/timeout detection and a pipelined scan of the register file and the low data memory bytes.
- Each scanned location is compared against an expected-value table that is loaded beforehand.
- Reports pass/fail, the mismatch count and the first failing location.
- Usable in simulation benches and on FPGA.

Parameters:
- XLEN, 32: register/data width.
- NREGS, 32: register-file entries scanned; must be a power of 2.
- MEM_BYTES, 128: data memory depth in bytes; must be a power of 2.
- CHECK_BYTES, 32: bytes scanned from address 0; 1 ≤ CHECK_BYTES ≤ MEM_BYTES.
- TIMEOUT, 1024: maximum RUN cycles before a forced scan.
- HALT_REPEAT, 2: consecutive cycles with unchanged pc_in that declare a halt (self-loop "jal x0,0").

Ports:
- clk, in, 1: system clock; all logic is rising-edge.
- reset, in, 1: asynchronous, active-low reset.
- start, in, 1: one-cycle pulse that arms the checker.
- pc_in, in, XLEN: core program counter.
- reg_raddr, out, log2(NREGS): register-file debug read address.
- reg_rdata, in, XLEN: register data; valid the cycle after reg_raddr is driven.
- mem_raddr, out, log2(MEM_BYTES): data-memory debug read address.
- mem_rdata, in, 8: memory byte; valid the cycle after mem_raddr is driven.
- exp_we, in, 1: expected-table write strobe.
- exp_sel, in, 1: table select; 0 = register table, 1 = memory table.
- exp_addr, in, log2(MEM_BYTES): table index.
- exp_data, in, XLEN: expected value; bits [7:0] only for the memory table.
- exp_en, in, 1: check-enable bit for this entry; 0 = don't care.
- busy, out, 1: high in RUN, SCAN_REG, SCAN_MEM and DRAIN.
- done, out, 1: high in DONE.
- pass, out, 1: valid while done is high.
- timed_out, out, 1: RUN ended by TIMEOUT.
- mismatch_count, out, 16: saturating count of mismatches.
- fail_valid, out, 1: a first failure has been captured.
- fail_is_mem, out, 1: first failure was a memory byte.
- fail_index, out, 8: index of the first failure.
- fail_actual, out, XLEN: actual value at the first failure, zero-extended for memory.
- fail_expected, out, XLEN: expected value at the first failure.
- cycle_count, out, 32: number of RUN cycles.

Behaviour:
- Reset (async assert, sync release): state = IDLE.
  - All outputs 0, including reg_raddr and mem_raddr.
  - Enable masks cleared.
  - Expected-value arrays are not reset.
- States: IDLE, RUN, SCAN_REG, SCAN_MEM, DRAIN, DONE.
- Table loading: exp_we is accepted in IDLE or DONE only and ignored elsewhere.
  - A write sets value[exp_addr] and en[exp_addr] for the selected table.
  - For exp_sel = 0, index bits above log2(NREGS) are ignored.
- IDLE/DONE + start → RUN, next cycle. This clears:
  - cycle_count, mismatch_count, all fail_* outputs, timed_out and pass;
  - the pc stability counter.
  - start in any other state is ignored.
- RUN:
  - cycle_count increments every cycle.
  - pc_in is registered each cycle; the stable counter increments when pc_in equals the previous sample, otherwise it reloads 0.
  - Stable counter reaching HALT_REPEAT−1 → SCAN_REG.
  - Else cycle_count reaching TIMEOUT−1 → SCAN_REG with timed_out = 1.
  - If both occur in the same cycle, halt wins and timed_out = 0.
  - The first sample after start never counts as stable.
- SCAN_REG: lasts NREGS cycles; reg_raddr = 0, 1, …, NREGS−1 on successive cycles.
- SCAN_MEM: lasts CHECK_BYTES cycles; mem_raddr = 0 … CHECK_BYTES−1.
- DRAIN: 1 cycle, then → DONE.
- Compare pipeline:
  - The index issued in cycle t is compared in cycle t+1 using the delayed index and table.
  - The last register compare overlaps the first SCAN_MEM cycle; the last byte compare occurs in DRAIN.
  - Compares with en = 0 are skipped.
  - x0 is compared like any other register.
- Mismatch handling: mismatch_count += 1, saturating at 16'hFFFF.
  - The first mismatch latches fail_valid, fail_is_mem, fail_index, fail_actual and fail_expected.
  - Later mismatches never overwrite the latched values.
- DONE:
  - done = 1, busy = 0.
  - pass = (mismatch_count == 0) && !timed_out.
  - Outputs hold until the next start.
  - done asserts exactly NREGS+CHECK_BYTES+1 cycles after the last RUN cycle.
- reset assertion in any state aborts immediately to IDLE with reset values.

Test Plan:
- Expected load: x5=07, x6=0, x7=0, x8=0000F0F0, x9=00000003 and mem[4]=0F, all enabled. Stub core matches and holds pc at 0x40 from cycle 10 → done at RUN-exit+65 (defaults), pass=1, mismatch_count=0, timed_out=0, fail_valid=0.
- Same load, stub x8=0000F0F1 and mem[4]=0E → mismatch_count=2, fail_is_mem=0, fail_index=8, fail_actual=0000F0F1, fail_expected=0000F0F0, pass=0.
- pc_in increments every cycle with TIMEOUT=16, data all matching → timed_out=1, cycle_count=16, pass=0.
- Mismatch on an entry with en=0 (x10 differs) → ignored, pass=1.
- reset low mid-SCAN_REG → immediately IDLE with all outputs 0. exp_we/start pulsed during RUN → table unchanged, run not restarted.
- Back-to-back runs: second start from DONE clears counters and fail_* outputs and rescans; MEM_BYTES=256, CHECK_BYTES=256 → last byte compared in DRAIN, fail_index=255 reported correctly.
